// File: rtl/cook_timer_ctrl_if.sv
// Control/status bundle for the microwave cook-time sequencer.
// The master side drives keypad/door inputs; the slave side is the controller.
interface cook_timer_ctrl_if;
  logic       load;
  logic [7:0] load_mm;
  logic [7:0] load_ss;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       mag_on;
  logic       done_beep;
  logic       load_err;
  logic [1:0] state;

  modport master (
    output load, load_mm, load_ss, start, stop, door_closed,
    input  mm, ss, mag_on, done_beep, load_err, state
  );

  modport slave (
    input  load, load_mm, load_ss, start, stop, door_closed,
    output mm, ss, mag_on, done_beep, load_err, state
  );
endinterface

// File: rtl/cook_timer_ctrl.sv
// Microwave cook-time sequencer: BCD mm:ss countdown on an internal 1 s tick,
// door/start/stop interlocks, magnetron enable and timed end-of-cook beep.
module cook_timer_ctrl #(
  parameter int DIV    = 100,
  parameter int BEEP_S = 3
) (
  input  logic                clk_in,
  input  logic                rst_n,
  cook_timer_ctrl_if.slave    bus_if
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COOK  = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (BEEP_S > 1) ? $clog2(BEEP_S) : 1;
  localparam logic [PW-1:0] PRE_TC  = PW'(DIV - 1);
  localparam logic [BW-1:0] BEEP_TC = BW'(BEEP_S - 1);

  state_e        state_q, state_d;
  logic [7:0]    mm_q, mm_d;
  logic [7:0]    ss_q, ss_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] beep_q, beep_d;
  logic          mag_on_q, done_beep_q, load_err_q, load_err_d;

  logic          tick, load_ok, time_nz;
  logic [7:0]    mm_dec, ss_dec;

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) bcd_dec = {v[7:4] - 4'd1, 4'd9};
    else                bcd_dec = {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign tick    = (presc_q == PRE_TC);
  assign time_nz = (mm_q != 8'h00) || (ss_q != 8'h00);
  assign load_ok = (bus_if.load_mm[7:4] <= 4'd9) && (bus_if.load_mm[3:0] <= 4'd9) &&
                   (bus_if.load_ss[7:4] <= 4'd5) && (bus_if.load_ss[3:0] <= 4'd9);

  // One-second countdown step: borrow from minutes when seconds hit 00.
  always_comb begin
    mm_dec = mm_q;
    ss_dec = ss_q;
    if (ss_q != 8'h00) begin
      ss_dec = bcd_dec(ss_q);
    end else if (mm_q != 8'h00) begin
      mm_dec = bcd_dec(mm_q);
      ss_dec = 8'h59;
    end
  end

  always_comb begin
    state_d    = state_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    presc_d    = presc_q;
    beep_d     = beep_q;
    load_err_d = bus_if.load && !load_ok;

    unique case (state_q)
      IDLE: begin
        // A load in the same cycle as start wins; start is dropped.
        if (bus_if.load) begin
          if (load_ok) begin
            mm_d = bus_if.load_mm;
            ss_d = bus_if.load_ss;
          end
        end else if (bus_if.start && !bus_if.stop && bus_if.door_closed && time_nz) begin
          state_d = COOK;
          presc_d = '0;
          beep_d  = '0;
        end
      end

      COOK: begin
        // Leaving for PAUSE freezes the prescaler so resume keeps the phase.
        if (!bus_if.door_closed || bus_if.stop) begin
          state_d = PAUSE;
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            mm_d = mm_dec;
            ss_d = ss_dec;
            if ((mm_dec == 8'h00) && (ss_dec == 8'h00)) begin
              state_d = DONE;
              presc_d = '0;
              beep_d  = '0;
            end
          end
        end
      end

      PAUSE: begin
        if (bus_if.stop) begin
          state_d = IDLE;
          mm_d    = 8'h00;
          ss_d    = 8'h00;
        end else if (bus_if.start && bus_if.door_closed) begin
          state_d = COOK;
        end
      end

      DONE: begin
        if (bus_if.start || bus_if.stop) begin
          state_d = IDLE;
          presc_d = '0;
          beep_d  = '0;
        end else begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (beep_q == BEEP_TC) begin
              state_d = IDLE;
              beep_d  = '0;
            end else begin
              beep_d = beep_q + BW'(1);
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mm_q        <= 8'h00;
      ss_q        <= 8'h00;
      presc_q     <= '0;
      beep_q      <= '0;
      mag_on_q    <= 1'b0;
      done_beep_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mm_q        <= mm_d;
      ss_q        <= ss_d;
      presc_q     <= presc_d;
      beep_q      <= beep_d;
      mag_on_q    <= (state_d == COOK);
      done_beep_q <= (state_d == DONE);
      load_err_q  <= load_err_d;
    end
  end

  assign bus_if.mm        = mm_q;
  assign bus_if.ss        = ss_q;
  assign bus_if.mag_on    = mag_on_q;
  assign bus_if.done_beep = done_beep_q;
  assign bus_if.load_err  = load_err_q;
  assign bus_if.state     = state_q;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed bench for cook_timer_ctrl with DIV=4, BEEP_S=3: a vector table
// for single-cycle behaviour plus hand sequences for multi-cycle corners.
module tb_cook_timer_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  cook_timer_ctrl_if bus_if ();

  cook_timer_ctrl #(.DIV(4), .BEEP_S(3)) dut (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [7:0] lmm;
    logic [7:0] lss;
    logic       st;
    logic       sp;
    logic       door;
    logic [7:0] emm;
    logic [7:0] ess;
    logic [1:0] est;
    logic       emag;
    logic       ebeep;
    logic       eerr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ld, input logic [7:0] lmm, input logic [7:0] lss,
                     input logic st, input logic sp, input logic door,
                     input logic [7:0] emm, input logic [7:0] ess, input logic [1:0] est,
                     input logic emag, input logic ebeep, input logic eerr);
    vec_t v;
    v.ld = ld; v.lmm = lmm; v.lss = lss; v.st = st; v.sp = sp; v.door = door;
    v.emm = emm; v.ess = ess; v.est = est; v.emag = emag; v.ebeep = ebeep; v.eerr = eerr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, sample after the next rising edge.
  task automatic cyc(input logic ld, input logic [7:0] lmm, input logic [7:0] lss,
                     input logic st, input logic sp, input logic door);
    bus_if.load        = ld;
    bus_if.load_mm     = lmm;
    bus_if.load_ss     = lss;
    bus_if.start       = st;
    bus_if.stop        = sp;
    bus_if.door_closed = door;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic door);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, door);
  endtask

  function automatic logic [31:0] obs();
    return {11'd0, bus_if.mm, bus_if.ss, bus_if.state,
            bus_if.mag_on, bus_if.done_beep, bus_if.load_err};
  endfunction

  function automatic logic [31:0] expv(input logic [7:0] m, input logic [7:0] s,
                                       input logic [1:0] st, input logic mg,
                                       input logic bp, input logic er);
    return {11'd0, m, s, st, mg, bp, er};
  endfunction

  initial begin
    bus_if.load = 1'b0; bus_if.load_mm = 8'h00; bus_if.load_ss = 8'h00;
    bus_if.start = 1'b0; bus_if.stop = 1'b0; bus_if.door_closed = 1'b1;

    //   ld    lmm    lss    st    sp    door   emm    ess    est  mag   beep  err
    add(1'b1, 8'h01, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 8'h05, 2'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 8'h05, 2'd0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h00, 8'h60, 1'b0, 1'b0, 1'b1, 8'h01, 8'h05, 2'd0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 8'h05, 2'd0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h9A, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 8'h05, 2'd0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 2'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h59, 2'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h59, 2'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h59, 2'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h59, 2'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 8'h58, 2'd1, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'h00, 8'h30, 1'b0, 1'b0, 1'b1, 8'h00, 8'h58, 2'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 8'h58, 2'd2, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h58, 2'd2, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);

    // Reset state
    #12;
    chk("reset_state", obs(), expv(8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].ld, tbl[i].lmm, tbl[i].lss, tbl[i].st, tbl[i].sp, tbl[i].door);
      chk($sformatf("vec%0d", i), obs(),
          expv(tbl[i].emm, tbl[i].ess, tbl[i].est, tbl[i].emag, tbl[i].ebeep, tbl[i].eerr));
    end

    // Full cook 00:02: 8 cycles of magnetron, 12 cycles of beep, back to IDLE.
    cyc(1'b1, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("full_start", obs(), expv(8'h00, 8'h02, 2'd1, 1'b1, 1'b0, 1'b0));
    for (int i = 1; i < 8; i++) begin
      idle(1'b1);
      chk($sformatf("full_mag%0d", i), {30'd0, bus_if.state}, 32'd1);
      if (i == 4) chk("full_ss01", {24'd0, bus_if.ss}, 32'h01);
    end
    idle(1'b1);
    chk("full_done", obs(), expv(8'h00, 8'h00, 2'd3, 1'b0, 1'b1, 1'b0));
    for (int i = 9; i < 20; i++) begin
      idle(1'b1);
      chk($sformatf("full_beep%0d", i), {30'd0, bus_if.done_beep, bus_if.mag_on}, 32'd2);
    end
    idle(1'b1);
    chk("full_end", obs(), expv(8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0));

    // Door drop at prescaler=2, resume keeps the sub-second phase.
    cyc(1'b1, 8'h00, 8'h10, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    chk("door_pause", obs(), expv(8'h00, 8'h10, 2'd2, 1'b0, 1'b0, 1'b0));
    idle(1'b0);
    idle(1'b0);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("door_open_start", obs(), expv(8'h00, 8'h10, 2'd2, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("resume", obs(), expv(8'h00, 8'h10, 2'd1, 1'b1, 1'b0, 1'b0));
    idle(1'b1);
    chk("resume_hold", {24'd0, bus_if.ss}, 32'h10);
    idle(1'b1);
    chk("resume_dec", {24'd0, bus_if.ss}, 32'h09);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("stop_pause", obs(), expv(8'h00, 8'h09, 2'd2, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("stop_idle", obs(), expv(8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0));

    // Door open on the tick edge: pause without decrementing.
    cyc(1'b1, 8'h00, 8'h10, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    chk("door_tick", obs(), expv(8'h00, 8'h10, 2'd2, 1'b0, 1'b0, 1'b0));
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);

    // Stop during beep returns to IDLE at once.
    cyc(1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("done_reached", obs(), expv(8'h00, 8'h00, 2'd3, 1'b0, 1'b1, 1'b0));
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("done_stop", obs(), expv(8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0));

    // Asynchronous reset mid-cook, between clock edges.
    cyc(1'b1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("pre_reset_mag", {31'd0, bus_if.mag_on}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", obs(), expv(8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1);
    chk("post_reset", obs(), expv(8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
